// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray counter and for benches and other blocks.
// Contents:
//   DefaultWidth : default counter width.
//   MaxWidth     : widest supported counter; helper functions work on words of this width.
//   bin2gray     : binary -> Gray.
//   gray2bin     : Gray -> binary (prefix XOR from the MSB down).
// Narrower values are passed zero-extended; the results stay zero-extended.
package gray_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned MaxWidth     = 32;

  typedef logic [MaxWidth-1:0] word_t;

  function automatic word_t bin2gray(word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(word_t g);
    word_t b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_encoder.sv
// Purely combinational binary-to-Gray encoder.
// Parameters:
//   WIDTH  : word width in bits.
// Ports:
//   bin_i  : binary input word.
//   gray_o : Gray code of bin_i.
module gray_encoder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Binary/Gray counter. The binary and Gray counts are held in separate flops.
// Both are loaded from the same next-state value, so gray_q always matches bin_q.
// No output has a combinational path from the inputs.
//
// Parameters:
//   WIDTH    : counter width, 2..32.
//   SATURATE : 0 = wrap at the terminal count, 1 = hold at the terminal count.
// Ports:
//   clk      : clock, rising edge.
//   rst      : asynchronous, active-high reset.
//   en       : count enable.
//   up_dn    : 1 = count up, 0 = count down. Present only with GRAY_CNT_DOWN_EN.
//   load     : synchronous load strobe. It has priority over en.
//   load_val : binary value to load.
//   bin_q    : registered binary count.
//   gray_q   : registered Gray code of bin_q.
//   term     : one-cycle pulse on a wrap or saturation event.
// Configuration macro:
//   GRAY_CNT_DOWN_EN : adds up_dn and the down-count logic. When it is undefined,
//                      the counter counts up only.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef GRAY_CNT_DOWN_EN
  input  logic             up_dn,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             term
);

  localparam logic [WIDTH-1:0] AllOnes = '1;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             term_d;

  // Next-state selection. Priority is load, then en, then hold.
  // At a limit, the count either wraps or holds, and term pulses in both cases.
  always_comb begin
    bin_d  = bin_q;
    term_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
`ifdef GRAY_CNT_DOWN_EN
      if (!up_dn) begin
        if (bin_q == '0) begin
          term_d = 1'b1;
          if (!SATURATE) bin_d = AllOnes;
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end else
`endif
      begin
        if (bin_q == AllOnes) begin
          term_d = 1'b1;
          if (!SATURATE) bin_d = '0;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
    end
  end

  gray_encoder #(
    .WIDTH (WIDTH)
  ) u_gray_encoder (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      term   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      term   <= term_d;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter at WIDTH=4.
// It runs a wrapping instance (dut) and a saturating instance (dut_sat) from the same inputs.
// Expected values come from constant tables and hand sequences.
// An arithmetic model checks the randomized run.
module tb_gray_code_counter;
  import gray_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] bin_q, gray_q, bin_s, gray_s;
  logic         term, term_s;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state for both instances.
  int unsigned m_bin  = 0;
  int unsigned m_sbin = 0;
  bit          m_term = 1'b0;
  bit          m_sterm = 1'b0;

  gray_code_counter #(
    .WIDTH    (W),
    .SATURATE (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
`ifdef GRAY_CNT_DOWN_EN
    .up_dn    (up_dn),
`endif
    .load     (load),
    .load_val (load_val),
    .bin_q    (bin_q),
    .gray_q   (gray_q),
    .term     (term)
  );

  gray_code_counter #(
    .WIDTH    (W),
    .SATURATE (1'b1)
  ) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
`ifdef GRAY_CNT_DOWN_EN
    .up_dn    (up_dn),
`endif
    .load     (load),
    .load_val (load_val),
    .bin_q    (bin_s),
    .gray_q   (gray_s),
    .term     (term_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies the count rules arithmetically.
  // A step that leaves 0..2^W-1 is a limit event: it either wraps modulo 2^W or holds.
  function automatic void model_step(input bit sat, input bit ld, input bit en_i, input bit up,
                                     input int unsigned lv, inout int unsigned b, output bit t);
    int unsigned modulus = 1 << W;
    int raw;
    t = 1'b0;
    if (ld) begin
      b = lv % modulus;
    end else if (en_i) begin
      raw = int'(b) + (up ? 1 : -1);
      if (raw < 0 || raw >= int'(modulus)) begin
        t = 1'b1;
        if (!sat) b = unsigned'((raw + int'(modulus)) % int'(modulus));
      end else begin
        b = unsigned'(raw);
      end
    end
  endfunction

  // One clock. The models see the same inputs the DUTs sample; outputs are read 1ns later.
  task automatic step();
    @(posedge clk);
    model_step(1'b0, load, en, up_dn, load_val, m_bin, m_term);
    model_step(1'b1, load, en, up_dn, load_val, m_sbin, m_sterm);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " bin"},       bin_q,  m_bin);
    check({tag, " gray"},      gray_q, bin2gray(m_bin));
    check({tag, " term"},      term,   m_term);
    check({tag, " sat bin"},   bin_s,  m_sbin);
    check({tag, " sat gray"},  gray_s, bin2gray(m_sbin));
    check({tag, " sat term"},  term_s, m_sterm);
  endtask

  typedef struct {
    logic         ld;
    logic         en;
    logic [W-1:0] lv;
    logic [W-1:0] eb;
    logic [W-1:0] eg;
    logic         et;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] prev_g;
    int           exp_b [3];
    int           exp_g [3];
    int           exp_t [3];

    // Wrapping instance, counting up.
    vecs[0] = '{1'b1, 1'b1, 4'hA, 4'hA, 4'hF, 1'b0};  // load wins over en
    vecs[1] = '{1'b0, 1'b0, 4'h0, 4'hA, 4'hF, 1'b0};  // hold
    vecs[2] = '{1'b0, 1'b1, 4'h0, 4'hB, 4'hE, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1};  // wrap
    vecs[5] = '{1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 4'h7, 4'h7, 4'h4, 1'b0};

    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; up_dn = 1'b1;
    #12;
    check("reset bin", bin_q, 0);
    check("reset gray", gray_q, 0);
    check("reset term", term, 0);
    check("reset sat bin", bin_s, 0);
    rst = 1'b0;

    // Asynchronous reset between edges while the count is 9.
    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0;
    check("load9 bin", bin_q, 9);
    #3 rst = 1'b1;
    #1;
    check("async rst bin", bin_q, 0);
    check("async rst gray", gray_q, 0);
    check("async rst term", term, 0);
    m_bin = 0; m_sbin = 0; m_term = 0; m_sterm = 0;
    // A load that arrives while reset is held is discarded.
    load = 1'b1; load_val = 4'd5; en = 1'b1;
    @(posedge clk);
    #1;
    check("load under rst", bin_q, 0);
    rst = 1'b0;
    step();
    check("first edge after rst", bin_q, 5);
    check("first edge after rst gray", gray_q, 4'h7);

    for (int i = 0; i < 8; i++) begin
      load = vecs[i].ld; en = vecs[i].en; load_val = vecs[i].lv; up_dn = 1'b1;
      step();
      check($sformatf("vec%0d bin", i), bin_q, vecs[i].eb);
      check($sformatf("vec%0d gray", i), gray_q, vecs[i].eg);
      check($sformatf("vec%0d term", i), term, vecs[i].et);
    end

    // Full up sweep through the wrap.
    load = 1'b1; load_val = '0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    prev_g = gray_q;
    for (int k = 0; k < 17; k++) begin
      step();
      check($sformatf("sweep%0d bin", k), bin_q, (k + 1) % 16);
      check($sformatf("sweep%0d gray", k), gray_q, bin2gray((k + 1) % 16));
      check($sformatf("sweep%0d term", k), term, (k == 15) ? 1 : 0);
      check($sformatf("sweep%0d hamming", k), $countones(gray_q ^ prev_g), 1);
      prev_g = gray_q;
    end

`ifdef GRAY_CNT_DOWN_EN
    // Down-count through 0.
    load = 1'b1; load_val = 4'd1; en = 1'b0;
    step();
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    exp_b = '{0, 15, 14}; exp_g = '{0, 8, 9}; exp_t = '{0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("down%0d bin", k), bin_q, exp_b[k]);
      check($sformatf("down%0d gray", k), gray_q, exp_g[k]);
      check($sformatf("down%0d term", k), term, exp_t[k]);
    end
    // The saturating instance holds at 0 and repeats term.
    load = 1'b1; load_val = '0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("satdn%0d bin", k), bin_s, 0);
      check($sformatf("satdn%0d term", k), term_s, 1);
    end
    up_dn = 1'b1;
`else
    exp_b = '{15, 15, 15}; exp_g = '{8, 8, 8}; exp_t = '{0, 1, 1};
`endif

    // The saturating instance holds at all-ones.
    load = 1'b1; load_val = 4'd14; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("sat%0d bin", k), bin_s, 15);
      check($sformatf("sat%0d gray", k), gray_s, 4'h8);
      check($sformatf("sat%0d term", k), term_s, (k == 0) ? 0 : 1);
    end

    // Randomized run compared against the model.
    en = 1'b0; load = 1'b1; load_val = '0;
    step();
    check_model("resync");
    for (int c = 0; c < 10000; c++) begin
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      load_val = W'($urandom_range(0, 15));
`ifdef GRAY_CNT_DOWN_EN
      up_dn    = $urandom_range(0, 1) == 1;
`endif
      step();
      check_model("rand");
      check("rand gray==bin2gray(bin)", gray_q, bin2gray(32'(bin_q)));
      check("rand gray2bin", gray2bin(32'(gray_q)), m_bin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
